// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-attached command RAM.
// The SPI_RAM_PARITY_EN macro selects the parity-protected array build.
package spi_ram_pkg;

    localparam int unsigned FRAME_W = 10;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage with a synchronous write port and an asynchronous read port.
// With SPI_RAM_PARITY_EN defined, each word carries an even-parity bit checked on read.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    output logic          perr
);

`ifdef SPI_RAM_PARITY_EN
    logic [8:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {even_par(wdata), wdata};
        end
    end

    assign rdata = mem[raddr][7:0];
    assign perr  = mem[raddr][8] ^ even_par(mem[raddr][7:0]);
`else
    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign perr  = 1'b0;
`endif

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, address registers and tx hold window for the SPI RAM.
// Optional parity checking is enabled by defining SPI_RAM_PARITY_EN.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned TX_HOLD   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               parity_err
);

    localparam int unsigned AW    = $clog2(MEM_DEPTH);
    localparam int unsigned CW    = $clog2(TX_HOLD + 1);
    localparam logic [8:0]  DEPTH = 9'(MEM_DEPTH);

    logic          rx_valid_q;
    logic          acc;
    cmd_t          cmd;
    logic [7:0]    pl;
    logic [7:0]    wr_addr;
    logic [7:0]    rd_addr;
    logic          wr_ok;
    logic          rd_ok;
    logic          rd_acc;
    logic [7:0]    rdata;
    logic          perr;
    hold_state_t   state;
    logic [CW-1:0] cnt;

    assign acc    = rx_valid & ~rx_valid_q;
    assign cmd    = cmd_t'(rx_data[FRAME_W-1:FRAME_W-2]);
    assign pl     = rx_data[7:0];
    assign wr_ok  = {1'b0, wr_addr} < DEPTH;
    assign rd_ok  = {1'b0, rd_addr} < DEPTH;
    assign rd_acc = acc && (cmd == RD_DATA);

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (acc && (cmd == WR_DATA) && wr_ok),
        .addr  (wr_addr[AW-1:0]),
        .wdata (pl),
        .raddr (rd_addr[AW-1:0]),
        .rdata (rdata),
        .perr  (perr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (acc) begin
                case (cmd)
                    WR_ADDR: wr_addr <= pl;
                    RD_ADDR: rd_addr <= pl;
                    default: ;
                endcase
            end
        end
    end

    // Any non-read command accepted during a window aborts it; tx_data keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_data <= '0;
        end else if (rd_acc) begin
            state   <= HOLD;
            cnt     <= CW'(TX_HOLD);
            tx_data <= rd_ok ? rdata : 8'h00;
        end else if (acc && (state == HOLD)) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == HOLD) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= IDLE;
            end
        end
    end

    assign tx_valid = (state == HOLD);

`ifdef SPI_RAM_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (rd_acc && rd_ok && perr) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    // The array drives perr low when parity is compiled out.
    assign parity_err = perr;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: a full-depth and a 128-word instance share stimulus.
// Defining SPI_RAM_PARITY_EN adds the parity corruption scenario.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;

    logic [7:0] tx_data_b, tx_data_s;
    logic       tx_valid_b, tx_valid_s;
    logic       perr_b, perr_s;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .TX_HOLD(9)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .parity_err (perr_b)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .TX_HOLD(9)) u_dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data_s),
        .tx_valid   (tx_valid_s),
        .parity_err (perr_s)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Window monitor on the full-depth instance.
    int   hi_cnt = 0;
    int   rise_cnt = 0;
    logic tv_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_valid_b) hi_cnt <= hi_cnt + 1;
        if (tx_valid_b && !tv_prev) rise_cnt <= rise_cnt + 1;
        tv_prev <= tx_valid_b;
    end

    // Reference model and scoreboard.
    logic [7:0] m_big [256];
    logic [7:0] m_sml [128];
    logic [7:0] wa = '0;
    logic [7:0] ra = '0;
    logic       exp_perr = 1'b0;
    logic [7:0] q_b [$];
    logic [7:0] q_s [$];
    int         base_hi, base_r;

    task automatic send(input logic [9:0] f, input int unsigned n);
        logic [7:0] pl;
        pl = f[7:0];
        case (f[9:8])
            2'b00: wa = pl;
            2'b01: begin
                m_big[wa] = pl;
                if (wa < 8'd128) m_sml[wa[6:0]] = pl;
            end
            2'b10: ra = pl;
            default: begin
                q_b.push_back(m_big[ra]);
                q_s.push_back((ra < 8'd128) ? m_sml[ra[6:0]] : 8'h00);
            end
        endcase
        @(negedge clk);
        rx_data  = f;
        rx_valid = 1'b1;
        repeat (n) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag);
        if (q_b.size() == 0 || q_s.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_data_b"}, 32'(tx_data_b), 32'(q_b.pop_front()));
            chk({tag, "_data_s"}, 32'(tx_data_s), 32'(q_s.pop_front()));
        end
        chk({tag, "_perr_b"}, 32'(perr_b), 32'(exp_perr));
        chk({tag, "_perr_s"}, 32'(perr_s), 32'd0);
    endtask

    task automatic mark();
        base_hi = hi_cnt;
        base_r  = rise_cnt;
    endtask

    task automatic win_chk(input string tag, input int hi_exp);
        chk({tag, "_win"}, 32'(hi_cnt - base_hi), 32'(hi_exp));
        chk({tag, "_rises"}, 32'(rise_cnt - base_r), 32'd1);
    endtask

    initial begin
        idle(3);
        chk("rst_data_b", 32'(tx_data_b), 32'h00);
        chk("rst_valid_b", 32'(tx_valid_b), 32'd0);
        chk("rst_perr_b", 32'(perr_b), 32'd0);
        chk("rst_data_s", 32'(tx_data_s), 32'h00);
        chk("rst_valid_s", 32'(tx_valid_s), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write then read; 0xA5 is out of range for the 128-word instance.
        mark();
        send(10'h0A5, 1); send(10'h15A, 1); send(10'h2A5, 1); send(10'h300, 1);
        chk("wr_rd_valid", 32'(tx_valid_b), 32'd1);
        chk("wr_rd_valid_s", 32'(tx_valid_s), 32'd1);
        rd_chk("wr_rd");
        idle(12);
        win_chk("wr_rd", 9);

        // Held rx_valid: one write, one window.
        send(10'h020, 1); send(10'h1FF, 5); send(10'h220, 1);
        mark();
        send(10'h300, 15);
        rd_chk("held");
        idle(4);
        win_chk("held", 9);

        // Restart at hold cycle 4.
        mark();
        send(10'h300, 1);
        rd_chk("rst1");
        idle(2);
        send(10'h300, 1);
        chk("restart_valid", 32'(tx_valid_b), 32'd1);
        rd_chk("rst2");
        idle(12);
        win_chk("restart", 13);

        // Abort by a WR_ADDR during hold.
        mark();
        send(10'h300, 1);
        rd_chk("abort_rd");
        idle(2);
        send(10'h000, 1);
        chk("abort_drop", 32'(tx_valid_b), 32'd0);
        chk("abort_hold", 32'(tx_data_b), 32'hFF);
        idle(3);
        win_chk("abort", 4);

        // Out-of-range write is dropped and out-of-range read returns zero.
        send(10'h000, 1); send(10'h177, 1); send(10'h080, 1); send(10'h1AA, 1);
        send(10'h200, 1); send(10'h300, 1);
        rd_chk("oor_keep");
        idle(10);
        send(10'h280, 1); send(10'h300, 1);
        chk("oor_valid_s", 32'(tx_valid_s), 32'd1);
        rd_chk("oor_rd");
        idle(10);

`ifdef SPI_RAM_PARITY_EN
        send(10'h010, 1); send(10'h13C, 1);
        @(negedge clk);
        u_dut.u_array.mem[16][0] = ~u_dut.u_array.mem[16][0];
        m_big[8'h10] = 8'h3D;
        exp_perr = 1'b1;
        send(10'h210, 1); send(10'h300, 1);
        rd_chk("par_bad");
        idle(10);
        send(10'h200, 1); send(10'h300, 1);
        rd_chk("par_sticky");
        idle(10);
`endif

        // Asynchronous reset in the middle of a window.
        send(10'h300, 1);
        chk("pre_rst_valid", 32'(tx_valid_b), 32'd1);
        rd_chk("pre_rst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_b", 32'(tx_data_b), 32'h00);
        chk("arst_valid_b", 32'(tx_valid_b), 32'd0);
        chk("arst_perr_b", 32'(perr_b), 32'd0);
        chk("arst_data_s", 32'(tx_data_s), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wa = '0;
        ra = '0;
        exp_perr = 1'b0;
        idle(1);
        send(10'h300, 1);
        rd_chk("post_rst");
        idle(10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data` frames, where bits [9:8] are the command and bits [7:0] the payload. It holds write and read address registers and performs memory writes. For read-data commands it returns the byte on `tx_data` with a `tx_valid` window long enough for the slave to shift it out on MISO.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; legal range 2..256.
- `TX_HOLD`, 9: cycles `tx_valid` stays asserted per read-data command; must be ≥ 1.
- `clk  in  1  single clock; all logic on the rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `rx_data  in  10  command frame from the SPI slave: [9:8] cmd, [7:0] payload`
- `rx_valid  in  1  frame valid; may be held high for several cycles`
- `tx_data  out  8  read data to the SPI slave`
- `tx_valid  out  1  read data valid window`
- `parity_err  out  1  sticky parity error flag; constant 0 when the parity feature is compiled out`

## Operation
- **Command acceptance.** One command per rising edge of `rx_valid`.
  - `rx_valid_q` is a registered copy of `rx_valid`.
  - Accept strobe: `acc = rx_valid & ~rx_valid_q`.
  - A level held for N cycles is exactly one command.
- **Commands** (`cmd = rx_data[9:8]`, `pl = rx_data[7:0]`):
  - `00 WR_ADDR`: `wr_addr <= pl`.
  - `01 WR_DATA`: `mem[wr_addr] <= pl`. Ignored if `wr_addr ≥ MEM_DEPTH`.
  - `10 RD_ADDR`: `rd_addr <= pl`.
  - `11 RD_DATA`: payload is ignored.
    - `tx_data <= mem[rd_addr]`, or 8'h00 if `rd_addr ≥ MEM_DEPTH`.
    - Loads the hold counter with `TX_HOLD`.
- **Address registers.** Both are 8 bits wide, never auto-increment, and persist across commands.
- **Hold state machine.** Two states, IDLE and HOLD.
  - IDLE → HOLD on an RD_DATA accept.
  - HOLD decrements the counter each cycle and returns to IDLE when the counter reaches 0.
  - An RD_DATA accept in HOLD reloads the counter and the data (restart).
  - Any other command accepted in HOLD aborts: `tx_valid` deasserts at that edge and `tx_data` holds its last value.
  - Counter width is `$clog2(TX_HOLD+1)`.
- **Reset values.**
  - `tx_data` = 0, `tx_valid` = 0, `parity_err` = 0.
  - `wr_addr` = 0, `rd_addr` = 0, `rx_valid_q` = 0, counter = 0, state = IDLE.
  - Memory contents are not reset and are undefined until written.
- **Reset mid-operation.** Asserting `rst_n` clears every register listed above immediately, without waiting for a clock edge. An in-flight hold window is dropped. Memory is untouched.

## Timing
- **Write.** Memory is updated at edge E, where E is the first edge with `rx_valid` = 1 and `rx_valid_q` = 0.
- **Read.**
  - `tx_data` and `tx_valid` are registered at edge E, so they are visible one cycle after `rx_valid` rises.
  - `tx_valid` is high after edges E .. E+TX_HOLD-1 and low after edge E+TX_HOLD, i.e. exactly `TX_HOLD` cycles.
- **Read latency.** Memory is read asynchronously into the output register, giving 1-cycle latency.
- **Read/write ordering.** A write to address A followed by an RD_DATA of A on the next accepted command returns the new value.
- **Hold vs. `rx_valid`.** `tx_valid` does not depend on `rx_valid` staying high; the upstream slave may keep `rx_valid` asserted throughout the window.

## Configuration
- Macro: `SPI_RAM_PARITY_EN`.
- **Defined:**
  - The array is 9 bits wide; bit 8 holds the even parity of the data, computed on WR_DATA.
  - On RD_DATA, parity is recomputed. On mismatch, `parity_err` is set at edge E and remains 1 until reset.
  - `tx_data` still returns the stored 8 bits.
  - Out-of-range reads never flag an error.
- **Undefined:**
  - The array is 8 bits wide and no parity logic exists.
  - `parity_err` is tied to 0; the port list is unchanged.

## Structure
- **Package `spi_ram_pkg`:**
  - `cmd_t` enum: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - `hold_state_t` enum: IDLE, HOLD.
  - Frame width constant `FRAME_W`=10.
- **Sub-module `spi_ram_array`:**
  - Storage plus optional parity generation and check.
  - Interfaces: write port (`we`, `addr`, `wdata`), async read port (`raddr`, `rdata`, `perr`).
  - The top level keeps command decode, address registers, edge detect and the hold FSM.

## Test plan
- **Reset:** assert `rst_n`=0 mid-clock → `tx_data`=8'h00, `tx_valid`=0 and `parity_err`=0 immediately, with no clock edge.
- **Write then read:** send frames 0x0A5, 0x15A, 0x2A5, 0x300 → `tx_data`=8'h5A one cycle after the 4th `rx_valid` rise; `tx_valid` high for exactly 9 cycles.
- **Held `rx_valid`:** hold `rx_valid` high for 15 cycles with 0x300 → only one 9-cycle `tx_valid` window, no retrigger. Also send 0x1FF held for 5 cycles → exactly one write, confirmed by readback of 8'hFF.
- **Restart and abort:** second 0x300 rise at hold cycle 4 → window restarts and `tx_valid` stays high for 4+9 cycles total. A 0x000 rise during hold → `tx_valid` drops after that edge.
- **Out of range (`MEM_DEPTH`=128):**
  - Frames 0x080, 0x1AA → no write; a prior value at mem[0x00] is unchanged.
  - Frames 0x280, 0x300 → `tx_data`=8'h00 with `tx_valid` asserted.
- **Parity (with `SPI_RAM_PARITY_EN`):**
  - Write 8'h3C to address 0x10, deposit a flip of stored bit 0, read 0x10 → `parity_err`=1 at the read edge.
  - It stays 1 after subsequent clean reads and clears only on reset.
